// File: rtl/jmp_br_pipe_pkg.sv
// Shared definitions for the jump/branch resolve pipe: op-bit indices, op vector type and FSM states.
package bj_pkg;

  localparam int OP_W    = 8;
  localparam int OP_JAL  = 0;
  localparam int OP_JALR = 1;
  localparam int OP_BEQ  = 2;
  localparam int OP_BNE  = 3;
  localparam int OP_BLT  = 4;
  localparam int OP_BGE  = 5;
  localparam int OP_BLTU = 6;
  localparam int OP_BGEU = 7;

  typedef logic [OP_W-1:0] op_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/jmp_br_pipe_if.sv
// Request, redirect and status bundle between the issue stage, fetch and the jump/branch pipe.
interface jmp_br_pipe_if
  import bj_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) ();

  logic             in_valid;
  logic             in_ready;
  op_t              op;
  logic             rvc;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  data1;
  logic [XLEN-1:0]  imm;
  logic             flag;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_pc;
  logic             flush;
  logic             redir_valid;
  logic             redir_ready;
  logic [XLEN-1:0]  redir_pc;
  logic             misalign;
  logic [XLEN-1:0]  misalign_addr;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output in_valid, op, rvc, pc, data1, imm, flag, pred_taken, pred_pc, flush, redir_ready,
    input  in_ready, redir_valid, redir_pc, misalign, misalign_addr, mispred_cnt
  );

  modport slave (
    input  in_valid, op, rvc, pc, data1, imm, flag, pred_taken, pred_pc, flush, redir_ready,
    output in_ready, redir_valid, redir_pc, misalign, misalign_addr, mispred_cnt
  );

endinterface

// File: rtl/jmp_br_resolve.sv
// Combinational jump/branch resolution: taken, target, fall-through, misalignment and mispredict.
module jmp_br_resolve
  import bj_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int IALIGN = 32
) (
  input  op_t             op,
  input  logic            rvc,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] imm,
  input  logic            flag,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_pc,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] fall_thru,
  output logic            misaligned,
  output logic            mispredict
);

  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] step;

  always_comb begin
    taken = op[OP_JAL] | op[OP_JALR]
          | (op[OP_BEQ] & flag)
          | (op[OP_BNE] & ~flag)
          | ((op[OP_BLT] | op[OP_BLTU]) & flag)
          | ((op[OP_BGE] | op[OP_BGEU]) & ~flag);

    jalr_sum = data1 + imm;
    if (op[OP_JALR]) target = {jalr_sum[XLEN-1:1], 1'b0};
    else             target = pc + imm;

    // Compressed step only exists when RVC is enabled; otherwise rvc is a don't-care.
    if (IALIGN == 16 && rvc) step = XLEN'(2);
    else                     step = XLEN'(4);
    fall_thru = pc + step;

    if (IALIGN == 32) misaligned = taken & target[1];
    else              misaligned = 1'b0;

    mispredict = (|op) & ~misaligned
               & ((taken != pred_taken) | (taken & (target != pred_pc)));
  end

endmodule

// File: rtl/jmp_br_pipe.sv
// Jump/branch resolve pipe: one-cycle resolution, redirect hold until fetch accepts, mispredict counter.
//   state | meaning
//   IDLE  | no redirect outstanding, always ready for a request
//   HOLD  | redirect presented to fetch, waiting for redir_ready
module jmp_br_pipe
  import bj_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int IALIGN = 32,
  parameter int CNT_W  = 32
) (
  input logic          clk,
  input logic          rst,
  jmp_br_pipe_if.slave bus
);

  state_t           state_q, state_d;
  logic [XLEN-1:0]  redir_pc_q, redir_pc_d;
  logic             misalign_q, misalign_d;
  logic [XLEN-1:0]  misalign_addr_q, misalign_addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             in_ready;
  logic             accept;
  logic             taken;
  logic [XLEN-1:0]  target;
  logic [XLEN-1:0]  fall_thru;
  logic             misaligned;
  logic             mispredict;

  jmp_br_resolve #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_resolve (
    .op         (bus.op),
    .rvc        (bus.rvc),
    .pc         (bus.pc),
    .data1      (bus.data1),
    .imm        (bus.imm),
    .flag       (bus.flag),
    .pred_taken (bus.pred_taken),
    .pred_pc    (bus.pred_pc),
    .taken      (taken),
    .target     (target),
    .fall_thru  (fall_thru),
    .misaligned (misaligned),
    .mispredict (mispredict)
  );

  assign in_ready = (state_q == IDLE) | bus.redir_ready;
  assign accept   = bus.in_valid & in_ready & ~bus.flush;

  always_comb begin
    state_d         = state_q;
    redir_pc_d      = redir_pc_q;
    misalign_d      = 1'b0;
    misalign_addr_d = misalign_addr_q;
    cnt_d           = cnt_q;

    // A flush kills both the outstanding redirect and any same-cycle request.
    if (bus.flush) begin
      state_d = IDLE;
    end else if (accept & mispredict) begin
      state_d    = HOLD;
      redir_pc_d = taken ? target : fall_thru;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end else if (state_q == HOLD && bus.redir_ready) begin
      state_d = IDLE;
    end

    if (accept & misaligned) begin
      misalign_d      = 1'b1;
      misalign_addr_d = target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      redir_pc_q      <= '0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
      cnt_q           <= '0;
    end else begin
      state_q         <= state_d;
      redir_pc_q      <= redir_pc_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
      cnt_q           <= cnt_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.redir_valid   = (state_q == HOLD);
  assign bus.redir_pc      = redir_pc_q;
  assign bus.misalign      = misalign_q;
  assign bus.misalign_addr = misalign_addr_q;
  assign bus.mispred_cnt   = cnt_q;

endmodule

// File: tb/tb_jmp_br_pipe.sv
// Scoreboard bench: two configurations (RV64 no-RVC, RV32 with RVC) driven by shared directed and random stimulus.
module tb_jmp_br_pipe;
  import bj_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s_valid, s_rvc, s_flag, s_pt, s_flush, s_rdy_a, s_rdy_b;
  logic [7:0]  s_op;
  logic [63:0] s_pc, s_d1, s_imm, s_ppc;

  jmp_br_pipe_if #(.XLEN(64), .CNT_W(4)) bus_a ();
  jmp_br_pipe_if #(.XLEN(32), .CNT_W(2)) bus_b ();

  jmp_br_pipe #(.XLEN(64), .IALIGN(32), .CNT_W(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  jmp_br_pipe #(.XLEN(32), .IALIGN(16), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  assign bus_a.in_valid = s_valid;    assign bus_b.in_valid = s_valid;
  assign bus_a.op = s_op;             assign bus_b.op = s_op;
  assign bus_a.rvc = s_rvc;           assign bus_b.rvc = s_rvc;
  assign bus_a.pc = s_pc;             assign bus_b.pc = s_pc[31:0];
  assign bus_a.data1 = s_d1;          assign bus_b.data1 = s_d1[31:0];
  assign bus_a.imm = s_imm;           assign bus_b.imm = s_imm[31:0];
  assign bus_a.flag = s_flag;         assign bus_b.flag = s_flag;
  assign bus_a.pred_taken = s_pt;     assign bus_b.pred_taken = s_pt;
  assign bus_a.pred_pc = s_ppc;       assign bus_b.pred_pc = s_ppc[31:0];
  assign bus_a.flush = s_flush;       assign bus_b.flush = s_flush;
  assign bus_a.redir_ready = s_rdy_a; assign bus_b.redir_ready = s_rdy_b;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  // Reference state per configuration (index 0 = RV64/IALIGN32, 1 = RV32/IALIGN16).
  bit hold [2] = '{0, 0};
  int cnt  [2] = '{0, 0};
  bit mexp [2] = '{0, 0};
  int xl   [2] = '{64, 32};
  int ial  [2] = '{32, 16};
  int cmax [2] = '{15, 3};
  logic [63:0] rq0[$], rq1[$], mq0[$], mq1[$];

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic int rq_size(input int k); return (k == 0) ? rq0.size() : rq1.size(); endfunction
  function automatic int mq_size(input int k); return (k == 0) ? mq0.size() : mq1.size(); endfunction
  function automatic logic [63:0] rq_front(input int k); return (k == 0) ? rq0[0] : rq1[0]; endfunction
  function automatic logic [63:0] mq_front(input int k); return (k == 0) ? mq0[0] : mq1[0]; endfunction

  task automatic rq_push(input int k, input logic [63:0] v);
    if (k == 0) rq0.push_back(v); else rq1.push_back(v);
  endtask
  task automatic mq_push(input int k, input logic [63:0] v);
    if (k == 0) mq0.push_back(v); else mq1.push_back(v);
  endtask
  task automatic rq_pop(input int k, input bit back);
    if (k == 0) begin if (back) void'(rq0.pop_back()); else void'(rq0.pop_front()); end
    else        begin if (back) void'(rq1.pop_back()); else void'(rq1.pop_front()); end
  endtask
  task automatic mq_pop(input int k);
    if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
  endtask
  task automatic q_clear(input int k);
    if (k == 0) begin rq0.delete(); mq0.delete(); end
    else        begin rq1.delete(); mq1.delete(); end
  endtask

  function automatic void resolve(input int xlen, input int ialign, input logic [7:0] op,
                                  input bit rvc, input logic [63:0] pc, input logic [63:0] d1,
                                  input logic [63:0] imm, input bit flag, input bit pt,
                                  input logic [63:0] ppc, output bit tk, output bit mis,
                                  output bit mp, output logic [63:0] tgt, output logic [63:0] redir);
    logic [63:0] m = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    logic [63:0] ft;
    case (op)
      8'h01, 8'h02:        tk = 1'b1;
      8'h04, 8'h10, 8'h40: tk = flag;
      8'h08, 8'h20, 8'h80: tk = !flag;
      default:             tk = 1'b0;
    endcase
    if (op == 8'h02) tgt = ((d1 + imm) & m) & ~64'h1;
    else             tgt = (pc + imm) & m;
    ft    = (pc + ((ialign == 16 && rvc) ? 64'd2 : 64'd4)) & m;
    mis   = (ialign == 32) && tk && tgt[1];
    mp    = (op != 8'h00) && !mis && ((tk != pt) || (tk && tgt != (ppc & m)));
    redir = tk ? tgt : ft;
  endfunction

  task automatic model_step(input int k, input bit rdy);
    bit tk, mis, mp;
    logic [63:0] tgt, redir;
    if (rst) begin
      hold[k] = 0; cnt[k] = 0; mexp[k] = 0; q_clear(k);
      return;
    end
    mexp[k] = 0;
    if (s_flush) begin
      if (hold[k] && !rdy) rq_pop(k, 1'b1);
      hold[k] = 0;
      return;
    end
    if (s_valid && (!hold[k] || rdy)) begin
      resolve(xl[k], ial[k], s_op, s_rvc, s_pc, s_d1, s_imm, s_flag, s_pt, s_ppc, tk, mis, mp, tgt, redir);
      if (mis) begin mexp[k] = 1; mq_push(k, tgt); end
      if (mp) begin
        rq_push(k, redir);
        if (cnt[k] < cmax[k]) cnt[k]++;
        hold[k] = 1;
      end else if (hold[k] && rdy) hold[k] = 0;
    end else if (hold[k] && rdy) hold[k] = 0;
  endtask

  task automatic check_side(input int k, input bit in_rdy, input bit rv, input logic [63:0] rpc,
                            input bit rdy, input bit mis, input logic [63:0] maddr, input int c);
    chk("in_ready", k, 64'(in_rdy), 64'(!hold[k] || rdy));
    chk("redir_valid", k, 64'(rv), 64'(hold[k]));
    if (rv) begin
      if (rq_size(k) == 0) begin
        total++; bad++;
        $display("FAIL redir_extra dut%0d: got redirect %0h expected none", k, rpc);
      end else begin
        chk("redir_pc", k, rpc, rq_front(k));
        if (rdy) rq_pop(k, 1'b0);
      end
    end
    chk("misalign", k, 64'(mis), 64'(mexp[k]));
    if (mis && mq_size(k) != 0) begin
      chk("misalign_addr", k, maddr, mq_front(k));
      mq_pop(k);
    end
    chk("mispred_cnt", k, 64'(c), 64'(cnt[k]));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check_side(0, bus_a.in_ready, bus_a.redir_valid, bus_a.redir_pc, s_rdy_a,
                 bus_a.misalign, bus_a.misalign_addr, int'(bus_a.mispred_cnt));
      check_side(1, bus_b.in_ready, bus_b.redir_valid, 64'(bus_b.redir_pc), s_rdy_b,
                 bus_b.misalign, 64'(bus_b.misalign_addr), int'(bus_b.mispred_cnt));
    end
  end

  task automatic cycle();
    @(negedge clk);
    #1;
    model_step(0, s_rdy_a);
    model_step(1, s_rdy_b);
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [7:0] op, input logic [63:0] pc, input logic [63:0] d1,
                    input logic [63:0] imm, input bit rvc, input bit flag, input bit pt,
                    input logic [63:0] ppc, input bit ra, input bit rb, input bit fl, input bit v);
    s_op = op; s_pc = pc; s_d1 = d1; s_imm = imm; s_rvc = rvc; s_flag = flag;
    s_pt = pt; s_ppc = ppc; s_rdy_a = ra; s_rdy_b = rb; s_flush = fl; s_valid = v;
    cycle();
  endtask

  task automatic idle(input bit ra, input bit rb, input bit fl);
    go(8'h00, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, ra, rb, fl, 1'b0);
  endtask

  initial begin
    bit tk, mis, mp;
    logic [63:0] tgt, redir;
    logic [31:0] r;
    int sel;

    rst = 1'b1;
    s_valid = 0; s_op = 0; s_rvc = 0; s_pc = 0; s_d1 = 0; s_imm = 0;
    s_flag = 0; s_pt = 0; s_ppc = 0; s_flush = 0; s_rdy_a = 0; s_rdy_b = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_redir_pc", 0, bus_a.redir_pc, 64'h0);
    chk("rst_misalign_addr", 0, bus_a.misalign_addr, 64'h0);
    chk("rst_redir_pc", 1, 64'(bus_b.redir_pc), 64'h0);
    chk("rst_misalign_addr", 1, 64'(bus_b.misalign_addr), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // beq taken but predicted not-taken, held three cycles, flushed in the second
    go(8'h04, 64'h1000, 64'h0, 64'h20, 0, 1, 0, 64'h0, 0, 0, 0, 1);
    idle(0, 0, 0);
    idle(0, 0, 1);
    idle(0, 0, 0);
    idle(1, 1, 0);
    // jalr with bit0 cleared, correctly predicted
    go(8'h02, 64'h0, 64'h2001, 64'h4, 0, 0, 1, 64'h2004, 1, 1, 0, 1);
    // jal to a halfword address
    go(8'h01, 64'h100, 64'h0, 64'h6, 0, 0, 0, 64'h0, 1, 1, 0, 1);
    idle(1, 1, 0);
    // compressed bne not taken, predicted taken; second case wraps in RV32
    go(8'h08, 64'h7FFE, 64'h0, 64'h40, 1, 1, 1, 64'h0, 1, 1, 0, 1);
    go(8'h08, 64'hFFFF_FFFE, 64'h0, 64'h40, 1, 1, 1, 64'h0, 1, 1, 0, 1);
    idle(1, 1, 0);
    // counter saturation from a clean reset
    rst = 1'b1; idle(0, 0, 0); rst = 1'b0;
    repeat (4) go(8'h04, 64'h1000, 64'h0, 64'h20, 0, 1, 0, 64'h0, 1, 1, 0, 1);
    idle(1, 1, 0);
    idle(1, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        s_valid = 1'b0; s_rdy_a = 1'b0; s_rdy_b = 1'b0;
        rst = 1'b1; cycle(); rst = 1'b0;
      end
      s_valid = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      s_op = (sel >= 8) ? 8'h00 : 8'(1 << sel);
      s_rvc = 1'($urandom_range(0, 1));
      s_flag = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       s_pc = 64'hFFFF_FFFF_FFFF_FFFE - 64'($urandom_range(0, 15) * 2);
        1:       s_pc = 64'hFFFF_FFFE - 64'($urandom_range(0, 15) * 2);
        default: s_pc = {32'($urandom), 32'($urandom)} & ~64'h1;
      endcase
      s_d1 = {32'($urandom), 32'($urandom)};
      r = $urandom;
      if ($urandom_range(0, 1) != 0) s_imm = {{32{r[31]}}, r};
      else                           s_imm = {{56{r[7]}}, r[7:0]};
      s_flush = ($urandom_range(0, 15) == 0);
      s_rdy_a = 1'($urandom_range(0, 1));
      s_rdy_b = 1'($urandom_range(0, 1));
      resolve(64, 32, s_op, s_rvc, s_pc, s_d1, s_imm, s_flag, 1'b0, 64'h0, tk, mis, mp, tgt, redir);
      s_pt  = ($urandom_range(0, 1) != 0) ? tk : 1'($urandom_range(0, 1));
      s_ppc = ($urandom_range(0, 1) != 0) ? tgt : {32'($urandom), 32'($urandom)};
      cycle();
    end

    repeat (4) idle(1, 1, 0);
    for (int k = 0; k < 2; k++) begin
      chk("redir_drained", k, 64'(rq_size(k)), 64'h0);
      chk("misalign_drained", k, 64'(mq_size(k)), 64'h0);
    end

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jmp_br_pipe.md
JMP_BR_PIPE -- requirements
Module: jmp_br_pipe

Interface
REQ-001 Parameter XLEN, default 64, datapath width in bits (32 or 64).
REQ-002 Parameter IALIGN, default 32, instruction alignment in bits (16 = RVC enabled, 32 = RVC disabled).
REQ-003 Parameter CNT_W, default 32, width of the mispredict counter.
REQ-004 clk  in  1  clock; single clock domain, all state rising-edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 in_valid  in  1  resolve request valid.
REQ-007 in_ready  out  1  unit can accept a request this cycle.
REQ-008 op  in  8  one-hot {bgeu,bltu,bge,blt,bne,beq,jalr,jal}; all-zero = non-control instruction.
REQ-009 rvc  in  1  instruction is 16-bit; ignored when IALIGN=32.
REQ-010 pc, data1, imm  in  XLEN  instruction PC, rs1 value, sign-extended immediate.
REQ-011 flag  in  1  ALU compare result (eq for beq/bne, lt for blt/bltu/bge/bgeu).
REQ-012 pred_taken  in  1; pred_pc  in  XLEN  front-end prediction for this instruction.
REQ-013 flush  in  1  kill from an older instruction.
REQ-014 redir_valid  out  1; redir_ready  in  1; redir_pc  out  XLEN  redirect handshake to fetch.
REQ-015 misalign  out  1; misalign_addr  out  XLEN  one-cycle instruction-address-misaligned exception.
REQ-016 mispred_cnt  out  CNT_W  saturating mispredict count.

Function
REQ-017 Accept occurs when in_valid & in_ready & ~flush; without accept, inputs are ignored.
REQ-018 Taken = jal | jalr | beq&flag | bne&~flag | (blt|bltu)&flag | (bge|bgeu)&~flag.
REQ-019 Target = pc+imm for jal/branches; (data1+imm) with bit0 cleared for jalr; all sums modulo 2^XLEN.
REQ-020 Fall-through = pc+2 when IALIGN=16 & rvc, otherwise pc+4, modulo 2^XLEN.
REQ-021 Misaligned = taken & target[1] when IALIGN=32; never when IALIGN=16.
REQ-022 Mispredict = op nonzero & ~misaligned & (taken != pred_taken | taken & target != pred_pc).
REQ-023 Resolution latency: one cycle; accepted request's results appear on outputs the following cycle.
REQ-024 States IDLE, HOLD; IDLE -> HOLD on accept with mispredict; HOLD -> IDLE on redir_ready without a new mispredict accept; HOLD -> HOLD on redir_ready with a new mispredict accept.
REQ-025 In HOLD, redir_valid=1 and redir_pc stable (taken ? target : fall-through) until redir_ready.
REQ-026 in_ready = (state==IDLE) | redir_ready.
REQ-027 misalign pulses one cycle after accept with misalign_addr = target; no redirect, no count.
REQ-028 mispred_cnt increments by 1 per accepted mispredict, saturates at all-ones.
REQ-029 flush has priority: same-cycle accept dropped; HOLD -> IDLE next cycle, redir_valid=0; pending misalign pulse suppressed; counter unchanged by the dropped request.
REQ-030 Non-control op (all-zero) accepted: no redirect, no misalign, no count.

Reset
REQ-031 On rst: state=IDLE, redir_valid=0, redir_pc=0, misalign=0, misalign_addr=0, mispred_cnt=0; in_ready=1 the cycle after rst deasserts.
REQ-032 rst in HOLD discards the pending redirect; rst overrides flush and accept.

Structure
REQ-033 Package bj_pkg holds the op-bit index constants, op vector typedef, and state enum {IDLE, HOLD}.
REQ-034 Combinational resolution (REQ-018..022) lives in sub-module jmp_br_resolve, parametrised by XLEN and IALIGN; jmp_br_pipe holds the FSM, output registers and counter.

Verification
REQ-035 XLEN=64, beq, flag=1, pc=0x1000, imm=0x20, pred_taken=0 -> next cycle redir_valid=1, redir_pc=0x1020, mispred_cnt=1.
REQ-036 jalr, data1=0x2001, imm=0x4, pred_taken=1, pred_pc=0x2004 -> no redirect, mispred_cnt unchanged.
REQ-037 IALIGN=32, jal, pc=0x100, imm=0x6 -> misalign=1 for one cycle, misalign_addr=0x106, no redirect; same with IALIGN=16 -> no misalign, pred_taken=0 gives redir_pc=0x106.
REQ-038 Mispredict with redir_ready=0 for 3 cycles -> redir_valid/redir_pc stable, in_ready=0; flush in cycle 2 -> redir_valid=0 next cycle, state IDLE.
REQ-039 CNT_W=2, four mispredicts -> mispred_cnt 1,2,3,3.
REQ-040 IALIGN=16, bne, flag=1, rvc=1, pc=0x7FFE (XLEN=32), pred_taken=1 -> redir_pc=0x8000; pc=0xFFFFFFFE -> redir_pc=0x0 (wrap).
